gp_lpddr5_cmd_timing_checker: RTL and testbench
===============================================

// Module: gp_lpddr5_cmd_timing_checker
// PURPOSE
//  Synthesizable LPDDR5 command/timing protocol checker, parametrised in rank count, bank count and timing.
//  Sits passively on the CA/CS bus of one LPDDR5 channel, sampled on ck_t.
//  Decodes commands and tracks per-rank/per-bank open state, tRCD/tRP, refresh interval and the CAS-sync window.
//  Reports violations as registered per-check flags plus a saturating error counter.
// PARAMETERS
//  NUM_RANKS   2     number of chip selects / ranks tracked independently
//  BANK_BITS   4     bank address width; banks = 2**BANK_BITS, bank field = ca[BANK_BITS-1:0]
//  T_RCD       4     min ck_t cycles ACT -> RD/WR to the same bank
//  T_RP        4     min ck_t cycles PRE -> ACT on the same rank
//  T_REFI_MAX  3900  max ck_t cycles between REFs per rank
//  CAS_WIN     1     cycles after CAS_WR/CAS_RD within which the matching WR/RD must arrive
//  CNT_W       16    width of internal timing counters (saturating)
//  ERR_CNT_W   16    width of err_count
// PORTS
//  ck_t        in   1          clock; all logic on posedge
//  ddr_reset   in   1          synchronous active-high reset
//  cs          in   NUM_RANKS  chip select per rank, active high
//  ca          in   7          command/address; ca[6]=CA0 ... ca[0]=CA6 (patterns below written CA0..CA6)
//  chk_en      in   7          per-check enable, bit order = err_flags
//  cmd_valid   out  1          registered: a decodable command was seen last cycle
//  cmd_code    out  4          registered decoded command (0 NOP,1 ACT,2 PRE,3 REF,4 WR16,5 WR32,6 MWR,7 RD16,8 RD32,9 CAS_WR,10 CAS_RD,11 CAS_FS,12 CAS_OFF,15 unknown)
//  err_valid   out  1          one-cycle pulse: any err_flags bit set
//  err_flags   out  7          [0]trcd [1]bank_idle [2]act_open [3]ref_open [4]trp [5]refi [6]cas
//  err_count   out  ERR_CNT_W  saturating count of cycles with err_valid
// BEHAVIOUR
//  - Reset: all outputs 0; all banks IDLE; tRCD/tRP counters saturated (no violation); refi counters 0; CAS state NONE, FS off.
//  - Decode when |cs: ACT 111xxxx; PRE 0001111 (all-bank); REF 0001110; WR16 011xxxx; MWR 010xxxx; RD16 100xxxx;
//    RD32 101xxxx; WR32 0010xxx; CAS_WR 0011100; CAS_RD 0011010; CAS_FS 0011001; CAS_OFF 0011111; else unknown.
//    cs==0 -> NOP, no state change. Command applies to every rank whose cs bit is 1.
//  - Latency: flags/cmd_code registered, 1 cycle after the sampling edge; state updates on the same edge.
//  - Per bank FSM: IDLE -ACT-> ACTIVE (clear its act counter); ACTIVE -PRE-> IDLE. Act counter increments each cycle, saturates.
//  - trcd: RD/WR/MWR to ACTIVE bank with act counter < T_RCD-1. bank_idle: RD/WR/MWR to IDLE bank (state unchanged).
//  - act_open: ACT to ACTIVE bank (bank stays ACTIVE, counter restarted). trp: ACT within T_RP cycles of PRE on that rank.
//  - ref_open: REF while any bank of that rank ACTIVE. REF clears rank refi counter.
//  - refi: refi counter reaches T_REFI_MAX without REF -> flag once; counter holds until next REF or reset.
//  - CAS sync FSM per channel: NONE, WAIT_WR, WAIT_RD, FS. CAS_WR->WAIT_WR, CAS_RD->WAIT_RD with window counter = CAS_WIN.
//    WAIT_WR: WR16/WR32/MWR -> NONE ok; RD or window expiry -> cas flag, NONE. WAIT_RD symmetric with RD16/RD32.
//    CAS_FS -> FS from any state; in FS RD/WR need no CAS; CAS_OFF -> NONE. CAS_OFF outside FS -> cas flag.
//    RD/WR/MWR in NONE -> cas flag. New CAS_WR/CAS_RD while waiting: cas flag, restart window with new type.
//  - Simultaneous errors: all applicable bits set same cycle; err_count increments by exactly 1, saturates at all-ones.
//  - chk_en bit 0: flag masked but state tracking unaffected.
//  - Timing counters saturate at 2**CNT_W-1; no wrap-around.
//  - ddr_reset mid-operation: state returns to reset values next edge; in-flight windows discarded, no flags.
// TESTING
//  - ACT b3 @0, WR16 b3 @2 (T_RCD=4, CAS_WR @1) -> err_flags[0]=1 at cycle 3, err_count=1.
//  - RD16 to bank 5 never activated (CAS_RD preceding) -> err_flags[1]=1, bank stays IDLE.
//  - ACT b0 then REF with b0 open -> err_flags[3]=1; PRE, wait 4, REF -> no flag.
//  - No REF for T_REFI_MAX=20 cycles -> single err_flags[5] pulse, none after until next REF.
//  - CAS_WR then NOP then WR16 (CAS_WIN=1) -> err_flags[6]; CAS_FS, RD16, WR16, CAS_OFF -> no flags.
//  - Errors 0x41 same cycle with err_count=ERR_CNT_W max -> both flags set, count stays max; ddr_reset -> all outputs 0.

Source files
------------

// File: rtl/gp_lpddr5_cmd_timing_checker.sv
// Passive LPDDR5 command/timing protocol checker for a single channel.
// Decodes the CA/CS bus, tracks per-rank/per-bank open state, tRCD, tRP,
// the refresh interval and the CAS-sync window, and reports violations.
module gp_lpddr5_cmd_timing_checker #(
    parameter int unsigned NUM_RANKS  = 2,
    parameter int unsigned BANK_BITS  = 4,
    parameter int unsigned T_RCD      = 4,
    parameter int unsigned T_RP       = 4,
    parameter int unsigned T_REFI_MAX = 3900,
    parameter int unsigned CAS_WIN    = 1,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned ERR_CNT_W  = 16
) (
    input  logic                 ck_t,
    input  logic                 ddr_reset,
    input  logic [NUM_RANKS-1:0] cs,
    input  logic [6:0]           ca,
    input  logic [6:0]           chk_en,
    output logic                 cmd_valid,
    output logic [3:0]           cmd_code,
    output logic                 err_valid,
    output logic [6:0]           err_flags,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned NUM_BANKS = 2 ** BANK_BITS;

    localparam int unsigned ERR_TRCD      = 0;
    localparam int unsigned ERR_BANK_IDLE = 1;
    localparam int unsigned ERR_ACT_OPEN  = 2;
    localparam int unsigned ERR_REF_OPEN  = 3;
    localparam int unsigned ERR_TRP       = 4;
    localparam int unsigned ERR_REFI      = 5;

    localparam logic [CNT_W-1:0]     CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]     TRCD_LAST = CNT_W'((T_RCD > 0) ? T_RCD - 1 : 0);
    localparam logic [CNT_W-1:0]     TRP_LAST  = CNT_W'((T_RP > 0) ? T_RP - 1 : 0);
    localparam logic [CNT_W-1:0]     REFI_LIM  = CNT_W'(T_REFI_MAX);
    localparam logic [CNT_W-1:0]     REFI_LAST = CNT_W'((T_REFI_MAX > 0) ? T_REFI_MAX - 1 : 0);
    localparam logic [CNT_W-1:0]     WIN_INIT  = CNT_W'(CAS_WIN);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

    typedef enum logic [3:0] {
        CMD_NOP     = 4'd0,
        CMD_ACT     = 4'd1,
        CMD_PRE     = 4'd2,
        CMD_REF     = 4'd3,
        CMD_WR16    = 4'd4,
        CMD_WR32    = 4'd5,
        CMD_MWR     = 4'd6,
        CMD_RD16    = 4'd7,
        CMD_RD32    = 4'd8,
        CMD_CAS_WR  = 4'd9,
        CMD_CAS_RD  = 4'd10,
        CMD_CAS_FS  = 4'd11,
        CMD_CAS_OFF = 4'd12,
        CMD_UNK     = 4'd15
    } cmd_e;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_e;

    typedef enum logic [1:0] {
        CAS_NONE    = 2'd0,
        CAS_WAIT_WR = 2'd1,
        CAS_WAIT_RD = 2'd2,
        CAS_FS      = 2'd3
    } cas_state_e;

    // Registered state
    bank_state_e          bank_q     [NUM_RANKS][NUM_BANKS];
    logic [CNT_W-1:0]     act_cnt_q  [NUM_RANKS][NUM_BANKS];
    logic [CNT_W-1:0]     pre_cnt_q  [NUM_RANKS];
    logic [CNT_W-1:0]     refi_cnt_q [NUM_RANKS];
    cas_state_e           cas_q;
    logic [CNT_W-1:0]     win_q;

    // Next-state / combinational terms
    bank_state_e          bank_d     [NUM_RANKS][NUM_BANKS];
    logic [CNT_W-1:0]     act_cnt_d  [NUM_RANKS][NUM_BANKS];
    logic [CNT_W-1:0]     pre_cnt_d  [NUM_RANKS];
    logic [CNT_W-1:0]     refi_cnt_d [NUM_RANKS];
    cas_state_e           cas_d;
    logic [CNT_W-1:0]     win_d;

    cmd_e                 cmd_c;
    logic [BANK_BITS-1:0] bank_c;
    logic                 is_rd_c;
    logic                 is_wr_c;
    logic [NUM_RANKS-1:0] rank_open_c;
    logic [5:0]           bank_err_c;
    logic                 cas_err_c;
    logic [6:0]           flags_c;
    logic                 cmd_valid_c;
    logic [ERR_CNT_W-1:0] err_count_c;

    assign bank_c = ca[BANK_BITS-1:0];

    // Command decode; pattern CA0..CA6 maps onto ca[6:0] as written
    always_comb begin
        cmd_c = CMD_NOP;
        if (|cs) begin
            case (ca[6:4])
                3'b111:  cmd_c = CMD_ACT;
                3'b011:  cmd_c = CMD_WR16;
                3'b010:  cmd_c = CMD_MWR;
                3'b100:  cmd_c = CMD_RD16;
                3'b101:  cmd_c = CMD_RD32;
                3'b001: begin
                    if (!ca[3]) begin
                        cmd_c = CMD_WR32;
                    end else begin
                        case (ca[2:0])
                            3'b100:  cmd_c = CMD_CAS_WR;
                            3'b010:  cmd_c = CMD_CAS_RD;
                            3'b001:  cmd_c = CMD_CAS_FS;
                            3'b111:  cmd_c = CMD_CAS_OFF;
                            default: cmd_c = CMD_UNK;
                        endcase
                    end
                end
                3'b000: begin
                    if (ca[3:0] == 4'b1111) begin
                        cmd_c = CMD_PRE;
                    end else if (ca[3:0] == 4'b1110) begin
                        cmd_c = CMD_REF;
                    end else begin
                        cmd_c = CMD_UNK;
                    end
                end
                default: cmd_c = CMD_UNK;
            endcase
        end
    end

    // Column command classes
    always_comb begin
        is_rd_c = (cmd_c == CMD_RD16) || (cmd_c == CMD_RD32);
        is_wr_c = (cmd_c == CMD_WR16) || (cmd_c == CMD_WR32) || (cmd_c == CMD_MWR);
    end

    // Per-rank "any bank open" summary used by the REF check
    always_comb begin
        rank_open_c = '0;
        for (int unsigned r = 0; r < NUM_RANKS; r++) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                if (bank_q[r][b] == BANK_ACTIVE) begin
                    rank_open_c[r] = 1'b1;
                end
            end
        end
    end

    // Bank FSMs, timing counters and bank/refresh checks
    always_comb begin
        bank_d     = bank_q;
        act_cnt_d  = act_cnt_q;
        pre_cnt_d  = pre_cnt_q;
        refi_cnt_d = refi_cnt_q;
        bank_err_c = '0;
        for (int unsigned r = 0; r < NUM_RANKS; r++) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                if (act_cnt_q[r][b] != CNT_MAX) begin
                    act_cnt_d[r][b] = act_cnt_q[r][b] + CNT_W'(1);
                end
            end
            if (pre_cnt_q[r] != CNT_MAX) begin
                pre_cnt_d[r] = pre_cnt_q[r] + CNT_W'(1);
            end
            // Refresh interval: flag once on reaching the limit, then hold
            if (cs[r] && (cmd_c == CMD_REF)) begin
                refi_cnt_d[r] = '0;
            end else if (refi_cnt_q[r] < REFI_LIM) begin
                refi_cnt_d[r] = refi_cnt_q[r] + CNT_W'(1);
                if (refi_cnt_q[r] == REFI_LAST) begin
                    bank_err_c[ERR_REFI] = 1'b1;
                end
            end
            if (cs[r]) begin
                case (cmd_c)
                    CMD_ACT: begin
                        if (bank_q[r][bank_c] == BANK_ACTIVE) begin
                            bank_err_c[ERR_ACT_OPEN] = 1'b1;
                        end
                        if (pre_cnt_q[r] < TRP_LAST) begin
                            bank_err_c[ERR_TRP] = 1'b1;
                        end
                        bank_d[r][bank_c]    = BANK_ACTIVE;
                        act_cnt_d[r][bank_c] = '0;
                    end
                    CMD_WR16, CMD_WR32, CMD_MWR, CMD_RD16, CMD_RD32: begin
                        if (bank_q[r][bank_c] == BANK_IDLE) begin
                            bank_err_c[ERR_BANK_IDLE] = 1'b1;
                        end else if (act_cnt_q[r][bank_c] < TRCD_LAST) begin
                            bank_err_c[ERR_TRCD] = 1'b1;
                        end
                    end
                    CMD_PRE: begin
                        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                            bank_d[r][b] = BANK_IDLE;
                        end
                        pre_cnt_d[r] = '0;
                    end
                    CMD_REF: begin
                        if (rank_open_c[r]) begin
                            bank_err_c[ERR_REF_OPEN] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // CAS-sync FSM next state and window check
    always_comb begin
        cas_d     = cas_q;
        win_d     = win_q;
        cas_err_c = 1'b0;
        if (cmd_c == CMD_CAS_FS) begin
            cas_d = CAS_FS;
        end else begin
            case (cas_q)
                CAS_NONE: begin
                    if (is_rd_c || is_wr_c || (cmd_c == CMD_CAS_OFF)) begin
                        cas_err_c = 1'b1;
                    end else if (cmd_c == CMD_CAS_WR) begin
                        cas_d = CAS_WAIT_WR;
                        win_d = WIN_INIT;
                    end else if (cmd_c == CMD_CAS_RD) begin
                        cas_d = CAS_WAIT_RD;
                        win_d = WIN_INIT;
                    end
                end
                CAS_WAIT_WR, CAS_WAIT_RD: begin
                    if ((cas_q == CAS_WAIT_WR && is_wr_c) || (cas_q == CAS_WAIT_RD && is_rd_c)) begin
                        cas_d = CAS_NONE;
                    end else if (is_rd_c || is_wr_c || (cmd_c == CMD_CAS_OFF)) begin
                        cas_err_c = 1'b1;
                        cas_d     = CAS_NONE;
                    end else if (cmd_c == CMD_CAS_WR) begin
                        cas_err_c = 1'b1;
                        cas_d     = CAS_WAIT_WR;
                        win_d     = WIN_INIT;
                    end else if (cmd_c == CMD_CAS_RD) begin
                        cas_err_c = 1'b1;
                        cas_d     = CAS_WAIT_RD;
                        win_d     = WIN_INIT;
                    end else if (win_q <= CNT_W'(1)) begin
                        cas_err_c = 1'b1;
                        cas_d     = CAS_NONE;
                    end else begin
                        win_d = win_q - CNT_W'(1);
                    end
                end
                CAS_FS: begin
                    if (cmd_c == CMD_CAS_OFF) begin
                        cas_d = CAS_NONE;
                    end
                end
                default: cas_d = CAS_NONE;
            endcase
        end
    end

    // Masked flags, decoded-command valid and saturating error count
    always_comb begin
        flags_c     = {cas_err_c, bank_err_c} & chk_en;
        cmd_valid_c = (cmd_c != CMD_NOP) && (cmd_c != CMD_UNK);
        err_count_c = err_count;
        if ((|flags_c) && (err_count != ERR_MAX)) begin
            err_count_c = err_count + ERR_CNT_W'(1);
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge ck_t) begin
        if (ddr_reset) begin
            for (int unsigned r = 0; r < NUM_RANKS; r++) begin
                for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                    bank_q[r][b]    <= BANK_IDLE;
                    act_cnt_q[r][b] <= CNT_MAX;
                end
                pre_cnt_q[r]  <= CNT_MAX;
                refi_cnt_q[r] <= '0;
            end
            cas_q     <= CAS_NONE;
            win_q     <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= 4'd0;
            err_valid <= 1'b0;
            err_flags <= '0;
            err_count <= '0;
        end else begin
            bank_q     <= bank_d;
            act_cnt_q  <= act_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
            refi_cnt_q <= refi_cnt_d;
            cas_q      <= cas_d;
            win_q      <= win_d;
            cmd_valid  <= cmd_valid_c;
            cmd_code   <= cmd_c;
            err_valid  <= |flags_c;
            err_flags  <= flags_c;
            err_count  <= err_count_c;
        end
    end

endmodule

// File: tb/tb_gp_lpddr5_cmd_timing_checker.sv
// Directed bench for the LPDDR5 command/timing checker.
module tb_gp_lpddr5_cmd_timing_checker;

    localparam int unsigned NUM_RANKS  = 2;
    localparam int unsigned BANK_BITS  = 4;
    localparam int unsigned T_RCD      = 4;
    localparam int unsigned T_RP       = 4;
    localparam int unsigned T_REFI_MAX = 20;
    localparam int unsigned CAS_WIN    = 1;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned ERR_CNT_W  = 4;

    localparam logic [6:0] EN_ALL  = 7'h7F;
    localparam logic [6:0] EN_NORF = 7'h5F;   // refresh-interval check masked

    localparam logic [6:0] C_NOP     = 7'h00;
    localparam logic [6:0] C_PRE     = 7'h0F;
    localparam logic [6:0] C_REF     = 7'h0E;
    localparam logic [6:0] C_CAS_WR  = 7'h1C;
    localparam logic [6:0] C_CAS_RD  = 7'h1A;
    localparam logic [6:0] C_CAS_FS  = 7'h19;
    localparam logic [6:0] C_CAS_OFF = 7'h1F;

    logic                 ck_t;
    logic                 ddr_reset;
    logic [NUM_RANKS-1:0] cs;
    logic [6:0]           ca;
    logic [6:0]           chk_en;
    logic                 cmd_valid;
    logic [3:0]           cmd_code;
    logic                 err_valid;
    logic [6:0]           err_flags;
    logic [ERR_CNT_W-1:0] err_count;

    typedef struct {
        logic [1:0] cs;
        logic [6:0] ca;
        logic [6:0] en;
        logic       valid;
        logic [3:0] code;
        logic [6:0] flags;
        logic [3:0] count;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_vec;
    int unsigned n_bad;

    gp_lpddr5_cmd_timing_checker #(
        .NUM_RANKS  (NUM_RANKS),
        .BANK_BITS  (BANK_BITS),
        .T_RCD      (T_RCD),
        .T_RP       (T_RP),
        .T_REFI_MAX (T_REFI_MAX),
        .CAS_WIN    (CAS_WIN),
        .CNT_W      (CNT_W),
        .ERR_CNT_W  (ERR_CNT_W)
    ) dut (
        .ck_t      (ck_t),
        .ddr_reset (ddr_reset),
        .cs        (cs),
        .ca        (ca),
        .chk_en    (chk_en),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .err_valid (err_valid),
        .err_flags (err_flags),
        .err_count (err_count)
    );

    initial ck_t = 1'b0;
    always #5 ck_t = ~ck_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] c,
                           input logic [6:0] f, input logic [3:0] n);
        chk({tag, ".cmd_valid"}, 32'(cmd_valid), 32'(v));
        chk({tag, ".cmd_code"},  32'(cmd_code),  32'(c));
        chk({tag, ".err_flags"}, 32'(err_flags), 32'(f));
        chk({tag, ".err_valid"}, 32'(err_valid), 32'(|f));
        chk({tag, ".err_count"}, 32'(err_count), 32'(n));
    endtask

    // Drive one command away from the edge, then sample just after the edge
    task automatic step(input logic [1:0] c, input logic [6:0] a, input logic [6:0] e);
        cs     = c;
        ca     = a;
        chk_en = e;
        @(posedge ck_t);
        #1;
    endtask

    task automatic do_reset(input string tag);
        ddr_reset = 1'b1;
        cs        = '0;
        ca        = '0;
        repeat (2) @(posedge ck_t);
        #1;
        ddr_reset = 1'b0;
        chk_out(tag, 1'b0, 4'd0, 7'h00, 4'd0);
    endtask

    task automatic add(input logic [1:0] c, input logic [6:0] a, input logic [6:0] e,
                       input logic v, input logic [3:0] code, input logic [6:0] f,
                       input logic [3:0] n);
        vec_t t;
        t.cs = c; t.ca = a; t.en = e; t.valid = v; t.code = code; t.flags = f; t.count = n;
        vecs.push_back(t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        chk_en = EN_NORF;

        // cs, ca, chk_en, exp cmd_valid, exp cmd_code, exp err_flags, exp err_count
        add(2'b01, 7'h73,     EN_NORF, 1, 4'd1,  7'h00, 4'd0);   // ACT b3
        add(2'b01, C_CAS_WR,  EN_NORF, 1, 4'd9,  7'h00, 4'd0);
        add(2'b01, 7'h33,     EN_NORF, 1, 4'd4,  7'h01, 4'd1);   // WR16 b3 2 cycles after ACT
        add(2'b01, C_CAS_RD,  EN_NORF, 1, 4'd10, 7'h00, 4'd1);
        add(2'b01, 7'h45,     EN_NORF, 1, 4'd7,  7'h02, 4'd2);   // RD16 idle b5
        add(2'b01, C_CAS_RD,  EN_NORF, 1, 4'd10, 7'h00, 4'd2);
        add(2'b01, 7'h45,     EN_NORF, 1, 4'd7,  7'h02, 4'd3);   // b5 still idle
        add(2'b01, C_CAS_RD,  EN_NORF, 1, 4'd10, 7'h00, 4'd3);
        add(2'b01, 7'h53,     EN_NORF, 1, 4'd8,  7'h00, 4'd3);   // RD32 b3 long after ACT
        add(2'b01, 7'h73,     EN_NORF, 1, 4'd1,  7'h04, 4'd4);   // ACT open b3
        add(2'b01, C_CAS_RD,  EN_NORF, 1, 4'd10, 7'h00, 4'd4);
        add(2'b01, 7'h43,     EN_NORF, 1, 4'd7,  7'h01, 4'd5);   // counter restarted
        add(2'b01, C_REF,     EN_NORF, 1, 4'd3,  7'h08, 4'd6);   // REF with b3 open
        add(2'b01, C_PRE,     EN_NORF, 1, 4'd2,  7'h00, 4'd6);
        add(2'b00, C_NOP,     EN_NORF, 0, 4'd0,  7'h00, 4'd6);
        add(2'b00, C_NOP,     EN_NORF, 0, 4'd0,  7'h00, 4'd6);
        add(2'b00, C_NOP,     EN_NORF, 0, 4'd0,  7'h00, 4'd6);
        add(2'b00, C_NOP,     EN_NORF, 0, 4'd0,  7'h00, 4'd6);
        add(2'b01, C_REF,     EN_NORF, 1, 4'd3,  7'h00, 4'd6);   // REF with all closed
        add(2'b01, C_PRE,     EN_NORF, 1, 4'd2,  7'h00, 4'd6);
        add(2'b01, 7'h70,     EN_NORF, 1, 4'd1,  7'h10, 4'd7);   // ACT right after PRE
        add(2'b01, C_PRE,     EN_NORF, 1, 4'd2,  7'h00, 4'd7);
        add(2'b00, C_NOP,     EN_NORF, 0, 4'd0,  7'h00, 4'd7);
        add(2'b00, C_NOP,     EN_NORF, 0, 4'd0,  7'h00, 4'd7);
        add(2'b00, C_NOP,     EN_NORF, 0, 4'd0,  7'h00, 4'd7);
        add(2'b01, 7'h70,     EN_NORF, 1, 4'd1,  7'h00, 4'd7);   // ACT exactly tRP after PRE
        add(2'b00, C_NOP,     EN_NORF, 0, 4'd0,  7'h00, 4'd7);
        add(2'b00, C_NOP,     EN_NORF, 0, 4'd0,  7'h00, 4'd7);
        add(2'b01, C_CAS_RD,  EN_NORF, 1, 4'd10, 7'h00, 4'd7);
        add(2'b01, 7'h40,     EN_NORF, 1, 4'd7,  7'h00, 4'd7);   // RD exactly tRCD after ACT
        add(2'b01, 7'h71,     EN_NORF, 1, 4'd1,  7'h00, 4'd7);   // ACT b1
        add(2'b00, C_NOP,     EN_NORF, 0, 4'd0,  7'h00, 4'd7);
        add(2'b01, C_CAS_WR,  EN_NORF, 1, 4'd9,  7'h00, 4'd7);
        add(2'b01, 7'h31,     EN_NORF, 1, 4'd4,  7'h01, 4'd8);   // WR one cycle short of tRCD
        add(2'b01, C_CAS_RD,  EN_NORF, 1, 4'd10, 7'h00, 4'd8);
        add(2'b01, 7'h47,     7'h5D,   1, 4'd7,  7'h00, 4'd8);   // bank_idle masked
        add(2'b10, 7'h70,     EN_NORF, 1, 4'd1,  7'h00, 4'd8);   // rank1 ACT b0
        add(2'b11, C_REF,     EN_NORF, 1, 4'd3,  7'h08, 4'd9);
        add(2'b11, C_PRE,     EN_NORF, 1, 4'd2,  7'h00, 4'd9);
        add(2'b01, 7'h00,     EN_NORF, 0, 4'd15, 7'h00, 4'd9);   // unknown pattern
        add(2'b01, 7'h22,     EN_NORF, 1, 4'd6,  7'h42, 4'd10);  // MWR idle, no CAS
        add(2'b01, 7'h12,     EN_NORF, 1, 4'd5,  7'h42, 4'd11);  // WR32 idle, no CAS
        add(2'b01, C_CAS_OFF, EN_NORF, 1, 4'd12, 7'h40, 4'd12);  // CAS_OFF outside FS
        add(2'b01, C_CAS_FS,  EN_NORF, 1, 4'd11, 7'h00, 4'd12);
        add(2'b01, C_CAS_OFF, EN_NORF, 1, 4'd12, 7'h00, 4'd12);
        add(2'b01, C_CAS_WR,  EN_NORF, 1, 4'd9,  7'h00, 4'd12);
        add(2'b01, C_CAS_RD,  EN_NORF, 1, 4'd10, 7'h40, 4'd13);  // new CAS while waiting
        add(2'b01, 7'h44,     EN_NORF, 1, 4'd7,  7'h02, 4'd14);  // RD matches restarted window

        do_reset("rst0");
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].cs, vecs[i].ca, vecs[i].en);
            chk_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].code, vecs[i].flags, vecs[i].count);
        end

        // CAS window expiry, then fast-sync mode
        do_reset("rst1");
        step(2'b01, 7'h71, EN_NORF);
        repeat (4) step(2'b00, C_NOP, EN_NORF);
        step(2'b01, C_CAS_WR, EN_NORF);
        step(2'b00, C_NOP, EN_NORF);
        chk_out("cas_expire", 1'b0, 4'd0, 7'h40, 4'd1);
        step(2'b01, 7'h31, EN_NORF);
        chk_out("cas_late_wr", 1'b1, 4'd4, 7'h40, 4'd2);
        step(2'b01, C_CAS_FS, EN_NORF);
        chk_out("fs_on", 1'b1, 4'd11, 7'h00, 4'd2);
        step(2'b01, 7'h41, EN_NORF);
        chk_out("fs_rd", 1'b1, 4'd7, 7'h00, 4'd2);
        step(2'b01, 7'h31, EN_NORF);
        chk_out("fs_wr", 1'b1, 4'd4, 7'h00, 4'd2);
        step(2'b01, C_CAS_OFF, EN_NORF);
        chk_out("fs_off", 1'b1, 4'd12, 7'h00, 4'd2);

        // Refresh interval: exactly one pulse per missed interval
        do_reset("rst2");
        for (int i = 1; i < 20; i++) begin
            step(2'b00, C_NOP, EN_ALL);
            chk($sformatf("refi_quiet%0d", i), 32'(err_flags), 32'h0);
        end
        step(2'b00, C_NOP, EN_ALL);
        chk_out("refi_hit", 1'b0, 4'd0, 7'h20, 4'd1);
        for (int i = 0; i < 10; i++) begin
            step(2'b00, C_NOP, EN_ALL);
            chk($sformatf("refi_hold%0d", i), 32'(err_flags), 32'h0);
        end
        step(2'b11, C_REF, EN_ALL);
        chk_out("refi_ref", 1'b1, 4'd3, 7'h00, 4'd1);
        for (int i = 1; i < 20; i++) begin
            step(2'b00, C_NOP, EN_ALL);
            chk($sformatf("refi_quiet_b%0d", i), 32'(err_flags), 32'h0);
        end
        step(2'b00, C_NOP, EN_ALL);
        chk_out("refi_hit2", 1'b0, 4'd0, 7'h20, 4'd2);

        // Reset discards an in-flight CAS window
        do_reset("rst3");
        step(2'b01, C_CAS_WR, EN_NORF);
        do_reset("rst4");
        step(2'b00, C_NOP, EN_NORF);
        chk_out("win_discard", 1'b0, 4'd0, 7'h00, 4'd0);

        // Counter saturation with simultaneous trcd+cas
        for (int i = 0; i < 15; i++) begin
            step(2'b01, C_CAS_OFF, EN_NORF);
        end
        chk_out("sat_fill", 1'b1, 4'd12, 7'h40, 4'd15);
        step(2'b01, 7'h72, EN_NORF);
        chk_out("sat_act", 1'b1, 4'd1, 7'h00, 4'd15);
        step(2'b01, 7'h32, EN_NORF);
        chk_out("sat_multi", 1'b1, 4'd4, 7'h41, 4'd15);
        do_reset("rst5");
        step(2'b01, 7'h32, EN_NORF);
        chk_out("post_rst_idle", 1'b1, 4'd4, 7'h42, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
